// File: rtl/addr2coor.sv
// Linear address -> (x, y) decoder for a COLS x ROWS grid.
// Four-step restoring division by COLS; out-of-range addresses report err.
module addr2coor #(
  parameter int COLS = 79,
  parameter int ROWS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [6:0]  x,
  output logic [3:0]  y,
  output logic        err,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam logic [11:0] LIMIT  = 12'(COLS * ROWS);
  localparam logic [10:0] COLS_W = 11'(COLS);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t      state, state_nx;
  logic [10:0] rem, rem_nx, sub;
  logic [1:0]  k, k_nx;
  logic [6:0]  x_nx;
  logic [3:0]  y_nx;
  logic        err_nx;

  // Row-block constant for the current step: COLS*8, *4, *2, *1.
  assign sub = COLS_W << k;

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    k_nx     = k;
    x_nx     = x;
    y_nx     = y;
    err_nx   = err;
    unique case (state)
      IDLE: if (in_valid) begin
        if ({1'b0, addr} >= LIMIT) begin
          err_nx   = 1'b1;
          x_nx     = '0;
          y_nx     = '0;
          state_nx = DONE;
        end else begin
          rem_nx   = addr;
          y_nx     = '0;
          k_nx     = 2'd3;
          state_nx = DIV;
        end
      end
      DIV: begin
        if (rem >= sub) begin
          rem_nx  = rem - sub;
          y_nx[k] = 1'b1;
        end else begin
          y_nx[k] = 1'b0;
        end
        // Remainder after the last step is < COLS, so 7 bits hold it exactly.
        if (k == 2'd0) begin
          x_nx     = rem_nx[6:0];
          err_nx   = 1'b0;
          state_nx = DONE;
        end else begin
          k_nx = k - 2'd1;
        end
      end
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      k     <= 2'd3;
      x     <= '0;
      y     <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      k     <= k_nx;
      x     <= x_nx;
      y     <= y_nx;
      err   <= err_nx;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
endmodule

// File: tb/tb_addr2coor.sv
// Directed bench for addr2coor: vector table, full in-range sweep,
// backpressure and mid-division reset sequences.
module tb_addr2coor;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] addr;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  x;
  logic [3:0]  y;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  addr2coor dut (
    .clk(clk), .rst(rst), .addr(addr), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] a;
    int ex;
    int ey;
    int ee;
    int lat;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge with the block idle. Returns result and the number of
  // edges after the accept edge until out_valid is seen; takes the result.
  task automatic do_req(input logic [10:0] a, output int rx, output int ry,
                        output int re, output int lat);
    int n;
    addr = a; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); @(negedge clk);
      lat++; n++;
    end
    chk("out_valid seen", int'(out_valid), 1);
    rx = int'(x); ry = int'(y); re = int'(err);
    @(posedge clk);
    @(negedge clk);
    chk("in_ready after take", int'(in_ready), 1);
    chk("out_valid after take", int'(out_valid), 0);
  endtask

  initial begin
    int rx, ry, re, lat;
    vt[0]  = '{11'd0,    0,  0, 0, 4};
    vt[1]  = '{11'd79,   0,  1, 0, 4};
    vt[2]  = '{11'd658,  26, 8, 0, 4};
    vt[3]  = '{11'd1263, 78, 15, 0, 4};
    vt[4]  = '{11'd1264, 0,  0, 1, 0};
    vt[5]  = '{11'd700,  68, 8, 0, 4};
    vt[6]  = '{11'd2047, 0,  0, 1, 0};
    vt[7]  = '{11'd1,    1,  0, 0, 4};
    vt[8]  = '{11'd78,   78, 0, 0, 4};
    vt[9]  = '{11'd128,  49, 1, 0, 4};
    vt[10] = '{11'd1185, 0,  15, 0, 4};
    vt[11] = '{11'd1500, 0,  0, 1, 0};
    vt[12] = '{11'd1000, 52, 12, 0, 4};

    rst = 1'b1; addr = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset x", int'(x), 0);
    chk("reset y", int'(y), 0);
    chk("reset err", int'(err), 0);

    // in_ready must drop right after the accept edge
    addr = 11'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready after accept", int'(in_ready), 0);
    repeat (6) begin @(posedge clk); @(negedge clk); end

    foreach (vt[i]) begin
      do_req(vt[i].a, rx, ry, re, lat);
      chk($sformatf("vec%0d x", i), rx, vt[i].ex);
      chk($sformatf("vec%0d y", i), ry, vt[i].ey);
      chk($sformatf("vec%0d err", i), re, vt[i].ee);
      chk($sformatf("vec%0d latency", i), lat, vt[i].lat);
    end

    for (int a = 0; a < 1264; a++) begin
      do_req(11'(a), rx, ry, re, lat);
      chk($sformatf("sweep %0d x", a), rx, a % 79);
      chk($sformatf("sweep %0d y", a), ry, a / 79);
      chk($sformatf("sweep %0d err", a), re, 0);
    end

    // Backpressure: result held, second request ignored
    addr = 11'd700; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    addr = 11'd5;
    for (int n = 0; n < 20 && !out_valid; n++) begin @(posedge clk); @(negedge clk); end
    chk("bp out_valid", int'(out_valid), 1);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); @(negedge clk);
      chk("bp hold x", int'(x), 68);
      chk("bp hold y", int'(y), 8);
      chk("bp hold valid", int'(out_valid), 1);
      chk("bp in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp no pass-through", int'(in_ready), 1);
    chk("bp valid dropped", int'(out_valid), 0);
    in_valid = 1'b0;
    do_req(11'd5, rx, ry, re, lat);
    chk("bp next x", rx, 5);
    chk("bp next y", ry, 0);

    // Reset while dividing: E0 accept, E1 k=3, E2 k=2, reset on E3 (k=1)
    addr = 11'd1000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("mid-reset in_ready", int'(in_ready), 1);
    chk("mid-reset out_valid", int'(out_valid), 0);
    chk("mid-reset x", int'(x), 0);
    chk("mid-reset y", int'(y), 0);
    chk("mid-reset err", int'(err), 0);
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); @(negedge clk);
      chk("mid-reset no pulse", int'(out_valid), 0);
    end
    do_req(11'd1000, rx, ry, re, lat);
    chk("post-reset x", rx, 52);
    chk("post-reset y", ry, 12);
    chk("post-reset err", re, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
